wait_state_memory: RTL
======================

Name: wait_state_memory

Overview:
- Parametrised bus slave memory for the shared tri-state bus. Successor to the fixed 4-entry test memory.
- Adds configurable depth, a base-address decode window, and independent read and write wait-state counts.
- Adds a one-access-per-strobe guard.
- Sits on the bus beside other slaves. Multiple instances are distinguished by ID and BASE_ADDR.

Parameters:
ID, 4'h0, tag placed in upper 4 bits of every reset-time word
DATA_WIDTH, 8, bus data width; must be >= 8
ADDR_WIDTH, 16, bus address width
DEPTH_LOG2, 2, memory holds 2**DEPTH_LOG2 words; range 1..4
BASE_ADDR, 0, window base; low DEPTH_LOG2 bits must be zero
RD_WAIT, 0, wait cycles inserted per read; range 0..15
WR_WAIT, 2, wait cycles inserted per write; range 0..15

Ports:
clk  input  1  bus clock
reset_n  input  1  asynchronous, active-low reset
ce_n  input  1  chip enable, active low
addr  input  ADDR_WIDTH  bus address
rd_n  input  1  read strobe, active low
wr_n  input  1  write strobe, active low
data  inout  DATA_WIDTH  bus data; driven only on selected reads, else Z
buswait_n  output  1  driven 0 while stalling the master, else Z
busrq_n  output  1  always Z; reserved for DMA
busack_n  input  1  unused; reserved

Behaviour:
- One clock: clk. Reset is asynchronous and active-low: reset_n.
- sel = !ce_n && addr[ADDR_WIDTH-1:DEPTH_LOG2] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2].
- idx = addr[DEPTH_LOG2-1:0].
- rd_req = sel && !rd_n && wr_n.
- wr_req = sel && !wr_n && rd_n.
- Both strobes low is a protocol error. It is ignored: no drive, no write, no wait, state unchanged.
- Reset, asynchronous on reset_n low:
  - state=IDLE, counter=0.
  - mem[i] = {ID, (DATA_WIDTH-4)-bit i}, i.e. ID in the upper 4 bits and i zero-extended in the lower bits.
  - buswait_n=Z, data=Z, busrq_n=Z, all immediately, not clock-gated.
  - Reset mid-access abandons the access. An uncommitted write is lost.
- data = mem[idx] whenever rd_req, combinationally, including during wait cycles. Otherwise Z.
- States are IDLE, WAIT and DONE.
  - IDLE:
    - rd_req with N=RD_WAIT, or wr_req with N=WR_WAIT.
    - N=0 -> DONE.
    - N=1 -> DONE.
    - N>=2 -> WAIT with counter=N-1.
  - WAIT: counter decrements each edge. At counter==1 -> DONE.
  - DONE: stays while sel && (!rd_n || !wr_n). Returns to IDLE on the first edge where the strobes are released or ce_n goes high.
- buswait_n = 0 when sel && ((IDLE && request && N>0) || WAIT). Otherwise Z.
  - Result: exactly N consecutive low cycles, starting combinationally in the cycle the strobe first appears.
- Write commit: mem[idx] <= data on the rising edge that leaves IDLE with wr_req, i.e. the first edge of the access.
  - Later data changes during WAIT or DONE are not stored.
- One access per strobe assertion. A long-held strobe produces no repeated writes or repeated wait periods.
- Abort: sel drops during WAIT -> buswait_n Z combinationally, state -> IDLE on the next edge. A write already committed stays.
- An address outside the window gives no response at all: Z outputs, no state change.
- The counter is 4 bits; no wrap is possible within the allowed range.
- busack_n is ignored.

Test Plan:
1. Reset defaults. ID=4'hA, BASE_ADDR=16'h0010, RD_WAIT=2, WR_WAIT=3. After reset, read 0x0010..0x0013 -> data A0, A1, A2, A3; buswait_n low exactly 2 cycles per read, then Z.
2. Write and read back. Write 0x5C to 0x0012 -> buswait_n low exactly 3 cycles. Read back 0x0012 -> 0x5C. Addresses 0x0010, 0x0011, 0x0013 still read A0, A1, A3.
3. Outside window. Read and write at 0x0014 and 0x000F -> data Z, buswait_n Z; reading 0x0010..0x0013 afterwards shows no memory change.
4. Long strobe. wr_n held low 10 cycles at 0x0011; data 0x11 at the first edge, changed to 0x22 after -> stored value 0x11; buswait_n low only 3 cycles; state returns to IDLE after wr_n rises.
5. Abort and protocol error.
   - ce_n raised in the 2nd wait cycle of a read -> buswait_n Z at once. A following read of 0x0013 waits exactly 2 cycles.
   - rd_n and wr_n both low -> no drive, no write, no wait.
6. Reset mid-access. reset_n pulsed low between clock edges during a write wait -> buswait_n and data Z immediately; all words back to A0..A3; the first access after release has normal wait timing.

Source files
------------

// File: rtl/wait_state_memory.sv
// rtl/wait_state_memory.sv - bus slave memory with address window and per-direction wait states
module wait_state_memory #(
    parameter logic [3:0]            ID         = 4'h0,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH_LOG2 = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RD_WAIT    = 0,
    parameter int                    WR_WAIT    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  rd_n,
    input  logic                  wr_n,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  buswait_n,
    output logic                  busrq_n,
    input  logic                  busack_n
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] RD_N  = 4'(RD_WAIT);
    localparam logic [3:0] WR_N  = 4'(WR_WAIT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state;
    logic [3:0]              counter;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    sel;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    rd_req;
    logic                    wr_req;
    logic                    req;
    logic [3:0]              n_req;
    logic                    stall;
    logic                    unused;

    assign sel    = !ce_n && (addr[ADDR_WIDTH-1:DEPTH_LOG2] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2]);
    assign idx    = addr[DEPTH_LOG2-1:0];
    assign rd_req = sel && !rd_n && wr_n;
    assign wr_req = sel && !wr_n && rd_n;
    assign req    = rd_req || wr_req;
    assign n_req  = wr_req ? WR_N : RD_N;

    // Outputs are gated by reset_n so they float the instant reset asserts.
    assign stall     = reset_n && sel && ((state == IDLE && req && n_req != 4'd0) || state == WAIT);
    assign buswait_n = stall ? 1'b0 : 1'bz;
    assign data      = (reset_n && rd_req) ? mem[idx] : {DATA_WIDTH{1'bz}};
    assign busrq_n   = 1'bz;
    assign unused    = busack_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            counter <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {ID, (DATA_WIDTH-4)'(i)};
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write data is captured only on the first edge of the access.
                        if (wr_req) begin
                            mem[idx] <= data;
                        end
                        if (n_req >= 4'd2) begin
                            state   <= WAIT;
                            counter <= n_req - 4'd1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (!sel) begin
                        state   <= IDLE;
                        counter <= 4'd0;
                    end else if (counter == 4'd1) begin
                        state   <= DONE;
                        counter <= 4'd0;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                DONE: begin
                    // Held strobes park here so one assertion yields one access.
                    if (!(sel && (!rd_n || !wr_n))) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
